mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port addrSel, input, 2, address source from the control unit: 00 PC, 01 register A, 10 ALU result, 11 reserved (address 16'h0000).
REQ-004 SHALL have ports pc, regA and aluOut, input, 16 each, candidate addresses.
REQ-005 SHALL have port saveOpcode, input, 1, control-unit request to fetch into the instruction register.
REQ-006 SHALL have port saveMem, input, 1, control-unit request to read into the internal value register.
REQ-007 SHALL have port memRdata, input, 16, external read data; valid only while memAck=1.
REQ-008 SHALL have port memAck, input, 1, external read-complete strobe.
REQ-009 SHALL have port memReq, output, 1, external read request.
REQ-010 SHALL have port memAddrOut, output, 16, external read address.
REQ-011 SHALL have port opcode, output, 16, instruction register.
REQ-012 SHALL have port memValue, output, 16, internal value register.
REQ-013 SHALL have port stall, output, 1, freezes the control-unit state register while high.
REQ-014 SHALL have port busErr, output, 1, sticky bus-timeout flag.
REQ-015 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles without memAck.

Function
REQ-016 SHALL implement the states IDLE, WAIT, DONE and ERROR.
REQ-017 IDLE, with saveOpcode or saveMem high: SHALL latch the selected address and the target (saveOpcode wins if both are high), assert stall combinationally, and go to WAIT.
REQ-018 IDLE, with no request: SHALL hold stall=0 and memReq=0.
REQ-019 WAIT: SHALL drive memReq=1, drive memAddrOut with the latched address (stable for the whole WAIT), and hold stall=1.
REQ-020 WAIT with memAck=1: SHALL write memRdata into the latched target register on that edge, leave the other register unchanged, clear the timeout counter, and go to DONE.
REQ-021 WAIT with memAck=0: SHALL increment the 4-bit timeout counter; when it reaches TIMEOUT, SHALL go to ERROR.
REQ-022 DONE: SHALL drive stall=0 and memReq=0, ignore saveOpcode and saveMem (these are the stale request), and go to IDLE.
REQ-023 ERROR: SHALL hold busErr=1, stall=1 and memReq=0, and leave only by reset.
REQ-024 Latency: request seen in cycle 0, memReq high from cycle 1, data registered at the edge where memAck is sampled, stall low in the following cycle; minimum 3 cycles per access.
REQ-025 memAck in IDLE, DONE or ERROR SHALL be ignored, with no register writes.
REQ-026 memAddrOut SHALL be 16'h0000 whenever memReq=0.
REQ-027 addrSel, pc, regA and aluOut changes after the IDLE capture SHALL NOT affect the address of the access in progress.

Reset
REQ-028 rst SHALL force, asynchronously: state IDLE, memReq=0, stall=0, busErr=0, opcode=16'h0000, memValue=16'h0000, timeout counter 0, latched address 0.
REQ-029 rst asserted during WAIT SHALL drop memReq in the same cycle and abandon the access with no register write.

Verification
REQ-030 Fetch: addrSel=00, pc=16'h0010, saveOpcode=1, memAck in the 2nd WAIT cycle with memRdata=16'h4A05 -> memAddrOut=16'h0010 while memReq=1; opcode=16'h4A05; stall high for 3 cycles then low 1 cycle.
REQ-031 Both requests: saveOpcode=1 and saveMem=1, addrSel=01, regA=16'h0200, data 16'h1234 -> opcode=16'h1234, memValue unchanged at 0.
REQ-032 Address hold: aluOut changes from 16'h0033 to 16'hFFFF during WAIT -> memAddrOut stays 16'h0033 for the whole access.
REQ-033 Timeout: memAck never asserted -> ERROR after 15 WAIT cycles; busErr=1, stall=1, memReq=0; a later memAck=1 causes no register change.
REQ-034 Reset mid-access: rst pulse in WAIT -> memReq=0 immediately, opcode=0, state IDLE; after release, a new fetch completes normally.
REQ-035 Stray ack: memAck=1 with memRdata=16'hBEEF in IDLE -> opcode and memValue unchanged, stall=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Sequences single-word reads from an external memory on behalf of the
// control unit. A fetch request (saveOpcode) or a data read request (saveMem)
// is captured in IDLE along with the address chosen by addrSel. The unit then
// holds memReq high until the memory strobes memAck, which writes memRdata
// into the requested register. If the memory never answers, the unit parks in
// a terminal error state. Only reset can clear that state.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   addrSel     address source: 00 pc, 01 regA, 10 aluOut, 11 reserved (0)
//   pc          candidate address (program counter)
//   regA        candidate address (register A)
//   aluOut      candidate address (ALU result)
//   saveOpcode  request: read into the instruction register (has priority)
//   saveMem     request: read into the value register
//   memRdata    read data, valid only while memAck is high
//   memAck      read-complete strobe from the memory
//   memReq      read request to the memory
//   memAddrOut  read address, forced to 0 whenever memReq is low
//   opcode      instruction register
//   memValue    value register
//   stall       freezes the control unit state while high
//   busErr      sticky bus-timeout flag
//
// Parameters
//   TIMEOUT     WAIT cycles without memAck before entering ERROR (1..15)
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addrSel,
  input  logic [15:0] pc,
  input  logic [15:0] regA,
  input  logic [15:0] aluOut,
  input  logic        saveOpcode,
  input  logic        saveMem,
  input  logic [15:0] memRdata,
  input  logic        memAck,
  output logic        memReq,
  output logic [15:0] memAddrOut,
  output logic [15:0] opcode,
  output logic [15:0] memValue,
  output logic        stall,
  output logic        busErr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [3:0] LP_TIMEOUT = 4'(TIMEOUT);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_addr;
  logic        r_tgt_opcode;   // 1: target is opcode, 0: target is memValue
  logic [3:0]  r_tmo_cnt;
  logic [15:0] r_opcode;
  logic [15:0] r_mem_value;

  logic [15:0] w_sel_addr;
  logic        w_req;
  logic        w_capture;
  logic        w_ack_write;
  logic [3:0]  w_tmo_next;

  assign w_req       = saveOpcode | saveMem;
  assign w_capture   = (r_state == ST_IDLE) && w_req;
  // memAck outside WAIT is deliberately ignored: no access is outstanding.
  assign w_ack_write = (r_state == ST_WAIT) && memAck;
  assign w_tmo_next  = r_tmo_cnt + 4'd1;

  always_comb begin
    unique case (addrSel)
      2'b00:   w_sel_addr = pc;
      2'b01:   w_sel_addr = regA;
      2'b10:   w_sel_addr = aluOut;
      default: w_sel_addr = 16'h0000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    memReq       = 1'b0;
    stall        = 1'b0;
    busErr       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Stall must rise in the request cycle itself so the control unit
        // does not advance past the instruction that asked for memory.
        if (w_req) begin
          stall        = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        memReq = 1'b1;
        stall  = 1'b1;
        // An ack in the last allowed cycle still wins over the timeout.
        if (memAck) begin
          w_next_state = ST_DONE;
        end else if (w_tmo_next == LP_TIMEOUT) begin
          w_next_state = ST_ERROR;
        end
      end
      ST_DONE: begin
        // The request inputs still show the access just served; skip them.
        w_next_state = ST_IDLE;
      end
      ST_ERROR: begin
        stall  = 1'b1;
        busErr = 1'b1;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Address, target, timeout counter and the two data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= 16'h0000;
      r_tgt_opcode <= 1'b0;
      r_tmo_cnt    <= 4'd0;
      r_opcode     <= 16'h0000;
      r_mem_value  <= 16'h0000;
    end else begin
      if (w_capture) begin
        // Address is frozen here; later changes on pc/regA/aluOut/addrSel
        // cannot disturb the access in flight.
        r_addr       <= w_sel_addr;
        r_tgt_opcode <= saveOpcode;
        r_tmo_cnt    <= 4'd0;
      end
      if (r_state == ST_WAIT) begin
        if (memAck) begin
          r_tmo_cnt <= 4'd0;
        end else begin
          r_tmo_cnt <= w_tmo_next;
        end
      end
      if (w_ack_write) begin
        if (r_tgt_opcode) begin
          r_opcode <= memRdata;
        end else begin
          r_mem_value <= memRdata;
        end
      end
    end
  end

  assign memAddrOut = memReq ? r_addr : 16'h0000;
  assign opcode     = r_opcode;
  assign memValue   = r_mem_value;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. A transaction-level model (an
// access in flight, a rest cycle after completion, a dead bus after timeout)
// predicts every output each cycle. Directed scenarios add literal
// expectations, followed by a randomized run with occasional resets.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addrSel = 2'b00;
  logic [15:0] pc = 16'h0000;
  logic [15:0] regA = 16'h0000;
  logic [15:0] aluOut = 16'h0000;
  logic        saveOpcode = 1'b0;
  logic        saveMem = 1'b0;
  logic [15:0] memRdata = 16'h0000;
  logic        memAck = 1'b0;
  logic        memReq;
  logic [15:0] memAddrOut;
  logic [15:0] opcode;
  logic [15:0] memValue;
  logic        stall;
  logic        busErr;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .addrSel    (addrSel),
    .pc         (pc),
    .regA       (regA),
    .aluOut     (aluOut),
    .saveOpcode (saveOpcode),
    .saveMem    (saveMem),
    .memRdata   (memRdata),
    .memAck     (memAck),
    .memReq     (memReq),
    .memAddrOut (memAddrOut),
    .opcode     (opcode),
    .memValue   (memValue),
    .stall      (stall),
    .busErr     (busErr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model
  logic        m_busy   = 1'b0;   // an access is outstanding on the bus
  logic        m_rest   = 1'b0;   // the cycle right after an access completed
  logic        m_dead   = 1'b0;   // memory never answered; only reset revives
  int          m_waited = 0;      // bus cycles spent without an answer
  logic [15:0] m_addr   = 16'h0000;
  logic        m_to_op  = 1'b0;
  logic [15:0] m_opcode = 16'h0000;
  logic [15:0] m_value  = 16'h0000;

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_w(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pick_addr(input logic [1:0] sel);
    case (sel)
      2'b00:   return pc;
      2'b01:   return regA;
      2'b10:   return aluOut;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic compare_model();
    logic        e_req;
    logic        e_stall;
    logic        e_err;
    logic [15:0] e_addr;
    e_req = 1'b0; e_stall = 1'b0; e_err = 1'b0; e_addr = 16'h0000;
    if (m_dead) begin
      e_stall = 1'b1; e_err = 1'b1;
    end else if (m_busy) begin
      e_req = 1'b1; e_stall = 1'b1; e_addr = m_addr;
    end else if (!m_rest) begin
      e_stall = saveOpcode | saveMem;
    end
    check_b("memReq", memReq, e_req);
    check_w("memAddrOut", memAddrOut, e_addr);
    check_b("stall", stall, e_stall);
    check_b("busErr", busErr, e_err);
    check_w("opcode", opcode, m_opcode);
    check_w("memValue", memValue, m_value);
  endtask

  // Advances the model across one rising edge using the inputs held there.
  task automatic model_step();
    if (rst) begin
      m_busy = 1'b0; m_rest = 1'b0; m_dead = 1'b0; m_waited = 0;
      m_addr = 16'h0000; m_to_op = 1'b0; m_opcode = 16'h0000; m_value = 16'h0000;
    end else if (m_dead) begin
      m_dead = 1'b1;
    end else if (m_busy) begin
      if (memAck) begin
        if (m_to_op) m_opcode = memRdata;
        else         m_value  = memRdata;
        m_busy = 1'b0;
        m_rest = 1'b1;
      end else begin
        m_waited++;
        if (m_waited >= TMO) begin
          m_busy = 1'b0;
          m_dead = 1'b1;
        end
      end
    end else if (m_rest) begin
      m_rest = 1'b0;
    end else if (saveOpcode || saveMem) begin
      m_busy   = 1'b1;
      m_addr   = pick_addr(addrSel);
      m_to_op  = saveOpcode;
      m_waited = 0;
    end
  endtask

  // Each cycle starts just after a falling edge with new inputs applied.
  task automatic settle();
    #2;
    if (!rst) compare_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic apply_reset();
    rst = 1'b1; saveOpcode = 1'b0; saveMem = 1'b0; memAck = 1'b0;
    #1;
    check_b("rst_memReq", memReq, 1'b0);
    check_w("rst_memAddrOut", memAddrOut, 16'h0000);
    check_b("rst_stall", stall, 1'b0);
    check_b("rst_busErr", busErr, 1'b0);
    check_w("rst_opcode", opcode, 16'h0000);
    check_w("rst_memValue", memValue, 16'h0000);
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    apply_reset();

    // Fetch from pc, ack in the second WAIT cycle.
    addrSel = 2'b00; pc = 16'h0010; saveOpcode = 1'b1;
    settle();
    check_b("fetch_stall_c0", stall, 1'b1);
    check_b("fetch_req_c0", memReq, 1'b0);
    advance();
    saveOpcode = 1'b0; pc = 16'h9999;
    settle();
    check_b("fetch_req_w1", memReq, 1'b1);
    check_w("fetch_addr_w1", memAddrOut, 16'h0010);
    check_b("fetch_stall_w1", stall, 1'b1);
    advance();
    memAck = 1'b1; memRdata = 16'h4A05;
    settle();
    check_w("fetch_addr_w2", memAddrOut, 16'h0010);
    check_b("fetch_stall_w2", stall, 1'b1);
    advance();
    memAck = 1'b0; memRdata = 16'h0000;
    settle();
    check_b("fetch_stall_done", stall, 1'b0);
    check_b("fetch_req_done", memReq, 1'b0);
    check_w("fetch_opcode", opcode, 16'h4A05);
    check_w("model_opcode", m_opcode, 16'h4A05);
    check_w("fetch_memValue", memValue, 16'h0000);
    advance();

    // Both requests at once: opcode wins, memValue untouched.
    addrSel = 2'b01; regA = 16'h0200; saveOpcode = 1'b1; saveMem = 1'b1;
    cycle();
    saveOpcode = 1'b0; saveMem = 1'b0; memAck = 1'b1; memRdata = 16'h1234;
    settle();
    check_w("both_addr", memAddrOut, 16'h0200);
    advance();
    memAck = 1'b0;
    settle();
    check_w("both_opcode", opcode, 16'h1234);
    check_w("both_memValue", memValue, 16'h0000);
    advance();

    // Address hold while the sources change during WAIT.
    addrSel = 2'b10; aluOut = 16'h0033; saveMem = 1'b1;
    cycle();
    saveMem = 1'b0; aluOut = 16'hFFFF; addrSel = 2'b00; pc = 16'h4321;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_w("hold_addr", memAddrOut, 16'h0033);
      advance();
    end
    memAck = 1'b1; memRdata = 16'h5A5A;
    settle();
    check_w("hold_addr_ack", memAddrOut, 16'h0033);
    advance();
    memAck = 1'b0;
    settle();
    check_w("hold_memValue", memValue, 16'h5A5A);
    check_w("hold_opcode", opcode, 16'h1234);
    advance();

    // Stray ack in IDLE.
    memAck = 1'b1; memRdata = 16'hBEEF;
    for (int k = 0; k < 2; k++) begin
      settle();
      check_b("stray_stall", stall, 1'b0);
      check_w("stray_opcode", opcode, 16'h1234);
      check_w("stray_memValue", memValue, 16'h5A5A);
      advance();
    end
    memAck = 1'b0;

    // Timeout: no ack ever.
    addrSel = 2'b00; pc = 16'h0040; saveOpcode = 1'b1;
    cycle();
    saveOpcode = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      settle();
      check_b("tmo_req", memReq, 1'b1);
      advance();
    end
    settle();
    check_b("tmo_busErr", busErr, 1'b1);
    check_b("tmo_stall", stall, 1'b1);
    check_b("tmo_req_err", memReq, 1'b0);
    check_w("tmo_addr_err", memAddrOut, 16'h0000);
    check_b("model_dead", m_dead, 1'b1);
    advance();
    memAck = 1'b1; memRdata = 16'h1111; saveOpcode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_w("err_opcode", opcode, 16'h1234);
      check_b("err_busErr", busErr, 1'b1);
      advance();
    end
    memAck = 1'b0; saveOpcode = 1'b0;

    // Reset mid-access, then a fresh fetch.
    apply_reset();
    pc = 16'h0020; saveOpcode = 1'b1;
    cycle();
    saveOpcode = 1'b0; memAck = 1'b1; memRdata = 16'h7777;
    cycle();
    memAck = 1'b0;
    cycle();
    pc = 16'h0030; saveOpcode = 1'b1;
    cycle();
    saveOpcode = 1'b0;
    settle();
    check_b("mid_req_before", memReq, 1'b1);
    check_w("mid_opcode_before", opcode, 16'h7777);
    rst = 1'b1;
    #1;
    check_b("mid_req_rst", memReq, 1'b0);
    check_w("mid_opcode_rst", opcode, 16'h0000);
    check_b("mid_stall_rst", stall, 1'b0);
    advance();
    rst = 1'b0;
    pc = 16'h0050; saveOpcode = 1'b1;
    cycle();
    saveOpcode = 1'b0;
    settle();
    check_w("post_rst_addr", memAddrOut, 16'h0050);
    advance();
    memAck = 1'b1; memRdata = 16'hC3C3;
    cycle();
    memAck = 1'b0;
    settle();
    check_w("post_rst_opcode", opcode, 16'hC3C3);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (m_dead || ($urandom_range(0, 199) == 0)) begin
        apply_reset();
      end else begin
        saveOpcode = ($urandom_range(0, 3) == 0);
        saveMem    = ($urandom_range(0, 3) == 0);
        addrSel    = 2'($urandom_range(0, 3));
        pc         = 16'($urandom);
        regA       = 16'($urandom);
        aluOut     = 16'($urandom);
        memAck     = ($urandom_range(0, 2) == 0);
        memRdata   = 16'($urandom);
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
